// File: rtl/tft_timing_pkg.sv
// Shared timing defaults, scan phases and RGB565 colours for the 480x272 TFT path.
package tft_timing_pkg;

    localparam int H_SYNC_DEF  = 41;
    localparam int H_BACK_DEF  = 2;
    localparam int H_DISP_DEF  = 480;
    localparam int H_FRONT_DEF = 2;
    localparam int V_SYNC_DEF  = 10;
    localparam int V_BACK_DEF  = 2;
    localparam int V_DISP_DEF  = 272;
    localparam int V_FRONT_DEF = 2;

    localparam int H_TOTAL = H_SYNC_DEF + H_BACK_DEF + H_DISP_DEF + H_FRONT_DEF;
    localparam int V_TOTAL = V_SYNC_DEF + V_BACK_DEF + V_DISP_DEF + V_FRONT_DEF;
    localparam int H_START = H_SYNC_DEF + H_BACK_DEF;
    localparam int V_START = V_SYNC_DEF + V_BACK_DEF;

    localparam logic [15:0] BLACK  = 16'h0000;
    localparam logic [15:0] BLUE   = 16'h001F;
    localparam logic [15:0] RED    = 16'hF800;
    localparam logic [15:0] PURPLE = 16'hF81F;
    localparam logic [15:0] GREEN  = 16'h07E0;
    localparam logic [15:0] CYAN   = 16'h07FF;
    localparam logic [15:0] YELLOW = 16'hFFE0;
    localparam logic [15:0] WHITE  = 16'hFFFF;

    typedef enum logic [1:0] {
        PH_SYNC,
        PH_BACK,
        PH_ACTIVE,
        PH_FRONT
    } phase_t;

    // Boundaries are exclusive upper ends of each phase along one axis.
    function automatic phase_t phase_of(input logic [9:0] cnt,
                                        input logic [9:0] sync_end,
                                        input logic [9:0] back_end,
                                        input logic [9:0] disp_end);
        phase_t ph;
        if (cnt < sync_end)
            ph = PH_SYNC;
        else if (cnt < back_end)
            ph = PH_BACK;
        else if (cnt < disp_end)
            ph = PH_ACTIVE;
        else
            ph = PH_FRONT;
        return ph;
    endfunction

endpackage

// File: rtl/tft_backlight_pwm.sv
// Backlight PWM: free-running 8-bit period, duty latched only at period end.
module tft_backlight_pwm
    import tft_timing_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bright,
    output logic       pwm
);

    logic [7:0] pwm_cnt;
    logic [7:0] duty;

    // Duty updates on the same edge that wraps the counter, so every period uses one value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= 8'd0;
            duty    <= 8'd0;
            pwm     <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (pwm_cnt == 8'hFF)
                duty <= bright;
            pwm <= (pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/tft_scan_timing.sv
// Scan counters, sync/DE generation and registered pixel output for an RGB565 TFT panel.
//   phase     | meaning
//   PH_SYNC   | sync pulse (HS/VS driven low)
//   PH_BACK   | back porch, blanked
//   PH_ACTIVE | visible pixels, req asserted when both axes active
//   PH_FRONT  | front porch, blanked
module tft_scan_timing
    import tft_timing_pkg::*;
#(
    parameter int H_SYNC  = H_SYNC_DEF,
    parameter int H_BACK  = H_BACK_DEF,
    parameter int H_DISP  = H_DISP_DEF,
    parameter int H_FRONT = H_FRONT_DEF,
    parameter int V_SYNC  = V_SYNC_DEF,
    parameter int V_BACK  = V_BACK_DEF,
    parameter int V_DISP  = V_DISP_DEF,
    parameter int V_FRONT = V_FRONT_DEF
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [15:0] data_in,
    input  logic [7:0]  bright,
    output logic [9:0]  hcount,
    output logic [9:0]  vcount,
    output logic        req,
    output logic        frame_start,
    output logic [15:0] TFT_RGB,
    output logic        TFT_HS,
    output logic        TFT_VS,
    output logic        TFT_DE,
    output logic        TFT_CLK,
    output logic        TFT_PWM
);

    localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
    localparam logic [9:0] H_ACT_BEG  = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_ACT_END  = 10'(H_SYNC + H_BACK + H_DISP);
    localparam logic [9:0] H_LAST     = 10'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
    localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
    localparam logic [9:0] V_ACT_BEG  = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_ACT_END  = 10'(V_SYNC + V_BACK + V_DISP);
    localparam logic [9:0] V_LAST     = 10'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    phase_t     h_phase;
    phase_t     v_phase;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= 10'd0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    assign h_phase = phase_of(h_cnt, H_SYNC_END, H_ACT_BEG, H_ACT_END);
    assign v_phase = phase_of(v_cnt, V_SYNC_END, V_ACT_BEG, V_ACT_END);

    assign req    = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
    assign hcount = req ? (h_cnt - H_ACT_BEG) : 10'd0;
    assign vcount = req ? (v_cnt - V_ACT_BEG) : 10'd0;

    // One register stage for every panel signal keeps RGB, DE and syncs aligned.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            TFT_RGB     <= BLACK;
            TFT_DE      <= 1'b0;
            TFT_HS      <= 1'b1;
            TFT_VS      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            TFT_RGB     <= req ? data_in : BLACK;
            TFT_DE      <= req;
            TFT_HS      <= (h_phase != PH_SYNC);
            TFT_VS      <= (v_phase != PH_SYNC);
            frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
        end
    end

    // Inverted clock puts the panel's sampling edge mid-way through each data cycle.
    assign TFT_CLK = ~Clk;

    tft_backlight_pwm u_pwm (
        .clk    (Clk),
        .rst    (Rst),
        .bright (bright),
        .pwm    (TFT_PWM)
    );

endmodule

// File: tb/tb_tft_scan_timing.sv
// Bench for tft_scan_timing: full-size instance for line timing, small instance for frames/PWM/reset.
module tb_tft_scan_timing;
    import tft_timing_pkg::*;

    localparam int SH_SYNC = 3, SH_BACK = 2, SH_DISP = 8, SH_FRONT = 2;
    localparam int SV_SYNC = 2, SV_BACK = 1, SV_DISP = 4, SV_FRONT = 1;
    localparam int SH_TOT   = SH_SYNC + SH_BACK + SH_DISP + SH_FRONT;
    localparam int SV_TOT   = SV_SYNC + SV_BACK + SV_DISP + SV_FRONT;
    localparam int SH_START = SH_SYNC + SH_BACK;
    localparam int SV_START = SV_SYNC + SV_BACK;
    localparam int SF_TOT   = SH_TOT * SV_TOT;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        d_rst, s_rst;
    logic [7:0]  d_bright, s_bright;
    logic [15:0] d_data_in, s_data_in;
    logic [9:0]  d_hcount, d_vcount, s_hcount, s_vcount;
    logic        d_req, d_fs, d_hs, d_vs, d_de, d_tclk, d_pwm;
    logic        s_req, s_fs, s_hs, s_vs, s_de, s_tclk, s_pwm;
    logic [15:0] d_rgb, s_rgb;

    int npass  = 0;
    int ntotal = 0;

    logic [16:0] sb_q[$];
    logic [2:0]  sy_q[$];

    assign d_data_in = {d_vcount[5:0], d_hcount};
    assign s_data_in = {s_vcount[5:0], s_hcount};

    tft_scan_timing u_full (
        .Clk(Clk), .Rst(d_rst), .data_in(d_data_in), .bright(d_bright),
        .hcount(d_hcount), .vcount(d_vcount), .req(d_req), .frame_start(d_fs),
        .TFT_RGB(d_rgb), .TFT_HS(d_hs), .TFT_VS(d_vs), .TFT_DE(d_de),
        .TFT_CLK(d_tclk), .TFT_PWM(d_pwm)
    );

    tft_scan_timing #(
        .H_SYNC(SH_SYNC), .H_BACK(SH_BACK), .H_DISP(SH_DISP), .H_FRONT(SH_FRONT),
        .V_SYNC(SV_SYNC), .V_BACK(SV_BACK), .V_DISP(SV_DISP), .V_FRONT(SV_FRONT)
    ) u_small (
        .Clk(Clk), .Rst(s_rst), .data_in(s_data_in), .bright(s_bright),
        .hcount(s_hcount), .vcount(s_vcount), .req(s_req), .frame_start(s_fs),
        .TFT_RGB(s_rgb), .TFT_HS(s_hs), .TFT_VS(s_vs), .TFT_DE(s_de),
        .TFT_CLK(s_tclk), .TFT_PWM(s_pwm)
    );

    task automatic test_reset();
        d_rst = 1'b1; s_rst = 1'b1; d_bright = 8'd0; s_bright = 8'd0;
        repeat (5) begin
            @(posedge Clk); #1;
            ntotal++; if (d_rgb !== 16'h0000) $display("FAIL rst_rgb got %0h want 0", d_rgb); else npass++;
            ntotal++; if ({d_de, d_hs, d_vs, d_fs, d_pwm, d_req} !== 6'b011000)
                $display("FAIL rst_ctl got %b want 011000", {d_de, d_hs, d_vs, d_fs, d_pwm, d_req}); else npass++;
            ntotal++; if ({s_de, s_hs, s_vs, s_fs, s_pwm} !== 5'b01100)
                $display("FAIL rst_small got %b want 01100", {s_de, s_hs, s_vs, s_fs, s_pwm}); else npass++;
        end
        d_rst = 1'b0; s_rst = 1'b0;
        ntotal++; if (d_tclk !== ~Clk) $display("FAIL tft_clk got %b want %b", d_tclk, ~Clk); else npass++;
        ntotal++; if (s_tclk !== ~Clk) $display("FAIL tft_clk_s got %b want %b", s_tclk, ~Clk); else npass++;
    endtask

    // Full-size timing: first DE edge after release, HS pulse width/period, line length.
    task automatic test_full_line();
        int k = 0, req_k = -1, de_k = -1;
        int c, last_fall, hs_run, de_run, nfall;
        logic prev_hs, prev_de;
        logic [15:0] prev_rgb, exp_last;
        @(posedge Clk); #1; k = 1;
        ntotal++; if (d_fs !== 1'b1) $display("FAIL fs_first got %b want 1", d_fs); else npass++;
        while (de_k < 0 && k < 7000) begin
            if (d_req && req_k < 0) begin
                req_k = k;
                ntotal++; if ({d_vcount, d_hcount} !== 20'd0)
                    $display("FAIL first_coord got %0d,%0d want 0,0", d_vcount, d_hcount); else npass++;
            end
            @(posedge Clk); #1; k++;
            if (d_de && de_k < 0) de_k = k;
        end
        ntotal++; if (req_k !== 12 * 525 + 43) $display("FAIL req_rise got %0d want %0d", req_k, 12 * 525 + 43); else npass++;
        ntotal++; if (de_k !== 12 * 525 + 44) $display("FAIL de_rise got %0d want %0d", de_k, 12 * 525 + 44); else npass++;
        ntotal++; if (d_rgb !== 16'h0000) $display("FAIL first_pix got %0h want 0", d_rgb); else npass++;
        prev_hs = d_hs; prev_de = d_de; prev_rgb = d_rgb;
        last_fall = -1; hs_run = 0; de_run = 1; nfall = 0;
        for (c = 0; c < 1100; c++) begin
            @(posedge Clk); #1;
            if (prev_hs && !d_hs) begin
                if (last_fall >= 0) begin
                    ntotal++; if (c - last_fall !== 525) $display("FAIL hs_period got %0d want 525", c - last_fall); else npass++;
                end
                last_fall = c; hs_run = 0;
            end
            if (!d_hs) hs_run++;
            if (!prev_hs && d_hs) begin
                ntotal++; if (hs_run !== 41) $display("FAIL hs_width got %0d want 41", hs_run); else npass++;
            end
            if (d_de) de_run++;
            if (prev_de && !d_de) begin
                exp_last = {6'(nfall), 10'd479};
                ntotal++; if (prev_rgb !== exp_last) $display("FAIL line_last_pix got %0h want %0h", prev_rgb, exp_last); else npass++;
                ntotal++; if (de_run !== 480) $display("FAIL de_per_line got %0d want 480", de_run); else npass++;
                ntotal++; if (d_rgb !== 16'h0000) $display("FAIL blank_rgb got %0h want 0", d_rgb); else npass++;
                nfall++; de_run = 0;
            end
            prev_hs = d_hs; prev_de = d_de; prev_rgb = d_rgb;
        end
        ntotal++; if (nfall !== 2) $display("FAIL line_count got %0d want 2", nfall); else npass++;
    endtask

    // Small instance, entered right after reset release: model counters drive a pixel/sync scoreboard.
    task automatic test_frames(input int nf);
        int mh = 0, mv = 0, t = 0, last_fs = -1, de_cnt = 0, vs_run = 0;
        logic exp_req;
        logic [9:0] ehc, evc;
        logic [16:0] e;
        logic [2:0] es;
        sb_q.delete(); sy_q.delete();
        for (int i = 0; i < nf * SF_TOT + 2; i++) begin
            exp_req = (mh >= SH_START) && (mh < SH_START + SH_DISP) && (mv >= SV_START) && (mv < SV_START + SV_DISP);
            ehc = exp_req ? 10'(mh - SH_START) : 10'd0;
            evc = exp_req ? 10'(mv - SV_START) : 10'd0;
            ntotal++; if ({s_req, s_vcount, s_hcount} !== {exp_req, evc, ehc})
                $display("FAIL coord @%0d,%0d got %b/%0d/%0d want %b/%0d/%0d", mv, mh, s_req, s_vcount, s_hcount, exp_req, evc, ehc);
            else npass++;
            sb_q.push_back({exp_req, exp_req ? {evc[5:0], ehc} : 16'h0000});
            sy_q.push_back({mh >= SH_SYNC, mv >= SV_SYNC, (mh == 0) && (mv == 0)});
            @(posedge Clk); #1; t++;
            e = sb_q.pop_front();
            es = sy_q.pop_front();
            ntotal++; if ({s_de, s_rgb} !== e) $display("FAIL pixel t=%0d got %b/%0h want %b/%0h", t, s_de, s_rgb, e[16], e[15:0]); else npass++;
            ntotal++; if ({s_hs, s_vs, s_fs} !== es) $display("FAIL sync t=%0d got %b want %b", t, {s_hs, s_vs, s_fs}, es); else npass++;
            if (s_fs) begin
                if (last_fs >= 0) begin
                    ntotal++; if (t - last_fs !== SF_TOT) $display("FAIL frame_period got %0d want %0d", t - last_fs, SF_TOT); else npass++;
                    ntotal++; if (de_cnt !== SH_DISP * SV_DISP) $display("FAIL de_per_frame got %0d want %0d", de_cnt, SH_DISP * SV_DISP); else npass++;
                end
                last_fs = t; de_cnt = 0;
            end
            if (s_de) de_cnt++;
            if (!s_vs) vs_run++;
            else if (vs_run > 0) begin
                ntotal++; if (vs_run !== SV_SYNC * SH_TOT) $display("FAIL vs_width got %0d want %0d", vs_run, SV_SYNC * SH_TOT); else npass++;
                vs_run = 0;
            end
            mh++;
            if (mh == SH_TOT) begin mh = 0; mv = (mv == SV_TOT - 1) ? 0 : mv + 1; end
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        while (!(s_req && s_hcount == 10'd4 && s_vcount == 10'd1) && n < 200) begin
            @(posedge Clk); #1; n++;
        end
        ntotal++; if (n >= 200) $display("FAIL mid_pos_timeout got %0d want <200", n); else npass++;
        @(posedge Clk); #1;
        ntotal++; if (s_de !== 1'b1) $display("FAIL mid_de_before got %b want 1", s_de); else npass++;
        s_rst = 1'b1; #1;
        ntotal++; if ({s_de, s_rgb, s_hs, s_vs, s_fs, s_req, s_hcount} !== {1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0})
            $display("FAIL mid_rst_async got %b/%0h/%b%b%b%b/%0d want 0/0/1100/0", s_de, s_rgb, s_hs, s_vs, s_fs, s_req, s_hcount);
        else npass++;
        repeat (3) begin
            @(posedge Clk); #1;
            ntotal++; if ({s_de, s_hs, s_vs, s_fs} !== 4'b0110) $display("FAIL mid_rst_hold got %b want 0110", {s_de, s_hs, s_vs, s_fs}); else npass++;
        end
        s_rst = 1'b0;
        test_frames(1);
    endtask

    // Duty sequence per period: 0 (reset latch), 64, 200 (changed mid-period), 0.
    task automatic test_pwm();
        int pc = 0, hi = 0, period = 0;
        logic [7:0] mb = 8'd0;
        logic exp_pwm;
        int exp_hi[4];
        exp_hi[0] = 0; exp_hi[1] = 64; exp_hi[2] = 200; exp_hi[3] = 0;
        s_rst = 1'b1;
        @(posedge Clk); #1;
        s_rst = 1'b0; s_bright = 8'd64;
        for (int i = 0; i < 1024; i++) begin
            if (period == 1 && pc == 100) s_bright = 8'd200;
            if (period == 2 && pc == 50) s_bright = 8'd0;
            exp_pwm = (pc < int'(mb));
            @(posedge Clk); #1;
            ntotal++; if (s_pwm !== exp_pwm) $display("FAIL pwm p=%0d c=%0d got %b want %b", period, pc, s_pwm, exp_pwm); else npass++;
            if (s_pwm) hi++;
            if (pc == 255) begin
                mb = s_bright;
                ntotal++; if (hi !== exp_hi[period]) $display("FAIL pwm_high p=%0d got %0d want %0d", period, hi, exp_hi[period]); else npass++;
                hi = 0; period++;
            end
            pc = (pc + 1) % 256;
        end
    endtask

    initial begin
        test_reset();
        test_full_line();
        test_reset();
        test_frames(2);
        test_mid_reset();
        test_pwm();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
